// File: rtl/mult_sched_pkg.sv
// ----------------------------------------------------------------------------
// mult_sched_pkg : shared widths and stage payload types for mult_share_scheduler
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mult_sched_pkg;

  localparam int PROD_W      = 32;
  localparam int MULT_DATA_W = 16;
  // Widest requester tag (16 requesters); narrower tags are zero-extended.
  localparam int MAX_ID_W    = 4;

  typedef struct packed {
    logic [MAX_ID_W-1:0]           id;
    logic signed [MULT_DATA_W-1:0] a;
    logic signed [MULT_DATA_W-1:0] b;
  } mult_req_t;

  typedef struct packed {
    logic [MAX_ID_W-1:0]      id;
    logic signed [PROD_W-1:0] product;
  } mult_resp_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter : one-hot round-robin grant, search starts one above ptr
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  int   cand;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= N; off++) begin
      cand = (int'(ptr) + off) % N;
      if (en && !found && req[cand[IW-1:0]]) begin
        found                = 1'b1;
        grant[cand[IW-1:0]]  = 1'b1;
        idx                  = cand[IW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wallace_tree_multiplier.sv
// ----------------------------------------------------------------------------
// wallace_tree_multiplier : combinational 16x16 signed multiplier, 32-bit product
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wallace_tree_multiplier
  import mult_sched_pkg::*;
(
  input  logic signed [MULT_DATA_W-1:0] A,
  input  logic signed [MULT_DATA_W-1:0] B,
  output logic signed [PROD_W-1:0]      Product
);

  // Operands are sign-extended to the product width before multiplying.
  assign Product = PROD_W'(A) * PROD_W'(B);

endmodule

`default_nettype wire

// File: rtl/mult_share_scheduler.sv
// ----------------------------------------------------------------------------
// mult_share_scheduler : round-robin sharing of one multiplier, 2-stage pipe
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mult_share_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [PROD_W-1:0]         resp_product,
  output logic                      idle,
  output logic [31:0]               op_count
);

  if (DATA_W != MULT_DATA_W) begin : g_bad_data_w
    $error("mult_share_scheduler: DATA_W must be 16");
  end

  mult_req_t         s1;
  logic              s1_valid;
  mult_resp_t        s2;
  logic              s2_valid;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gnt_idx;
  logic              s1_adv;
  logic              s2_adv;
  logic              accept;
  logic [PROD_W-1:0] mult_out;

  assign s2_adv = !s2_valid || resp_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign accept = |(req_valid & req_ready);

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .req   (req_valid),
    .en    (en && s1_adv),
    .ptr   (rr_ptr),
    .grant (req_ready),
    .idx   (gnt_idx)
  );

  wallace_tree_multiplier u_mult (
    .A       (s1.a),
    .B       (s1.b),
    .Product (mult_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s1_valid <= 1'b0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      s1.id    <= MAX_ID_W'(gnt_idx);
      s1.a     <= req_a[int'(gnt_idx)*DATA_W +: DATA_W];
      s1.b     <= req_b[int'(gnt_idx)*DATA_W +: DATA_W];
      s1_valid <= 1'b1;
      rr_ptr   <= gnt_idx;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Payload only loads with a real operation so the response bus stays quiet on bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2       <= '0;
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2.id      <= s1.id;
        s2.product <= mult_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (s2_valid && resp_ready) begin
      op_count <= op_count + 32'd1;
    end
  end

  assign resp_valid   = s2_valid;
  assign resp_id      = s2.id[ID_W-1:0];
  assign resp_product = s2.product;
  assign idle         = !s1_valid && !s2_valid;

endmodule

`default_nettype wire
